// File: rtl/spi_tx_responder_if.sv
// rtl/spi_tx_responder_if.sv - SPI return-path pins and response handshake bundle
interface spi_tx_responder_if #(
    parameter int NBYTES = 3
);
    logic                  cs;
    logic                  sck;
    logic                  sdo;
    logic                  sdo_en;
    logic [8*NBYTES-1:0]   tx_data;
    logic                  tx_valid;
    logic                  tx_ack;
    logic                  busy;
    logic                  tx_done;
    logic                  tx_err;

    modport master (
        output cs, sck, tx_data, tx_valid,
        input  sdo, sdo_en, tx_ack, busy, tx_done, tx_err
    );

    modport slave (
        input  cs, sck, tx_data, tx_valid,
        output sdo, sdo_en, tx_ack, busy, tx_done, tx_err
    );
endinterface

// File: rtl/spi_tx_responder.sv
// rtl/spi_tx_responder.sv - SPI mode-0 peripheral transmitter, MSB-first, fabric-clocked
module spi_tx_responder #(
    parameter int NBYTES      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_tx_responder_if.slave bus
);
    localparam int NBITS  = 8 * NBYTES;
    localparam int CW     = $clog2(NBITS + 2);
    localparam int SETTLE = SYNC_STAGES + 1;
    localparam int SW     = $clog2(SETTLE + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(NBITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(NBITS + 1);
    localparam logic [SW-1:0] SETTLED  = SW'(SETTLE);

    typedef enum logic [1:0] {
        WAIT_HIGH,
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync;
    logic                   cs_s, sck_s, cs_d, sck_d;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;
    logic [SW-1:0]          settle_cnt;
    logic                   settled;

    logic [NBITS-1:0]       shift_reg;
    logic [CW-1:0]          bit_cnt;
    logic                   sdo_q, active_q, ack_q, done_q, err_q;

    logic load, finish, shift_en, count_en;

    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign settled = (settle_cnt == SETTLED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync  <= '1;
            sck_sync <= '0;
            cs_d     <= 1'b1;
            sck_d    <= 1'b0;
            cs_fall  <= 1'b0;
            cs_rise  <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            cs_d     <= cs_s;
            sck_d    <= sck_s;
            cs_fall  <= cs_d & ~cs_s;
            cs_rise  <= ~cs_d & cs_s;
            sck_rise <= ~sck_d & sck_s;
            sck_fall <= sck_d & ~sck_s;
        end
    end

    // The synchronizer resets to "cs high", so WAIT_HIGH only trusts cs_s once
    // real pin data has flushed through; otherwise a cs held low would start a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_HIGH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        finish   = 1'b0;
        shift_en = 1'b0;
        count_en = 1'b0;
        case (state_q)
            WAIT_HIGH: begin
                if (settled && cs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                // cs_rise outranks any sck edge landing in the same cycle
                if (cs_rise) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end else begin
                    shift_en = sck_fall;
                    count_en = sck_rise;
                end
            end
            default: state_d = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            sdo_q     <= 1'b0;
            active_q  <= 1'b0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            active_q <= (state_d == SHIFT);
            ack_q    <= load & bus.tx_valid;
            done_q   <= finish;
            err_q    <= finish & (bit_cnt != CNT_FULL);
            if (load) begin
                shift_reg <= bus.tx_valid ? bus.tx_data : '0;
                sdo_q     <= bus.tx_valid & bus.tx_data[NBITS-1];
                bit_cnt   <= '0;
            end else if (finish) begin
                shift_reg <= '0;
                sdo_q     <= 1'b0;
            end else begin
                if (shift_en) begin
                    shift_reg <= {shift_reg[NBITS-2:0], 1'b0};
                    sdo_q     <= shift_reg[NBITS-2];
                end
                if (count_en && bit_cnt != CNT_SAT) begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.sdo     = sdo_q;
    assign bus.sdo_en  = active_q;
    assign bus.busy    = active_q;
    assign bus.tx_ack  = ack_q;
    assign bus.tx_done = done_q;
    assign bus.tx_err  = err_q;
endmodule

// File: tb/tb_spi_tx_responder.sv
// tb/tb_spi_tx_responder.sv - scoreboard bench with an MCU-side bit sampler
module tb_spi_tx_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_tx_responder_if #(.NBYTES(3)) ifc ();

    spi_tx_responder #(.NBYTES(3), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (ifc.slave)
    );

    typedef struct {
        logic [31:0] bits;
        int          n;
        logic        err;
        int          acks;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] rx_val = '0;
    int          rx_n   = 0;
    int          ack_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // MCU side: mode 0 samples sdo on the rising sck edge
    initial begin
        forever begin
            @(posedge ifc.sck);
            if (!rst) begin
                rx_val = {rx_val[30:0], ifc.sdo};
                rx_n++;
                check("sdo_en_at_sample", 32'(ifc.sdo_en), 32'd1);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ifc.tx_ack) ack_cnt++;
                if (ifc.tx_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_tx_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_err", 32'(ifc.tx_err), 32'(e.err));
                        check("bit_count", 32'(rx_n), 32'(e.n));
                        check("rx_bits", rx_val, e.bits);
                        check("ack_count", 32'(ack_cnt), 32'(e.acks));
                        check("sdo_en_after_done", {30'd0, ifc.sdo_en, ifc.busy}, 32'd0);
                    end
                    ack_cnt = 0;
                    rx_val  = '0;
                    rx_n    = 0;
                end
            end
        end
    end

    task automatic run_frame(input logic [23:0] d, input logic v, input int nbits,
                             input int hp, input bit collide);
        exp_t e;
        logic [23:0] word;
        word   = v ? d : 24'd0;
        e.bits = '0;
        for (int i = 0; i < nbits; i++) begin
            e.bits = {e.bits[30:0], (i < 24) ? word[23-i] : 1'b0};
        end
        e.n    = nbits;
        e.err  = (nbits != 24);
        e.acks = v ? 1 : 0;
        exp_q.push_back(e);
        ifc.tx_data  = d;
        ifc.tx_valid = v;
        @(posedge clk); #1;
        ifc.cs = 1'b0;
        repeat (hp) @(posedge clk);
        #1;
        for (int i = 0; i < nbits; i++) begin
            ifc.sck = 1'b1;
            repeat (hp) @(posedge clk);
            #1;
            ifc.sck = 1'b0;
            if (collide && i == nbits - 1) begin
                ifc.cs = 1'b1;
            end else begin
                repeat (hp) @(posedge clk);
                #1;
            end
        end
        ifc.cs = 1'b1;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("tx_done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] d;
        int nb;
        ifc.cs       = 1'b1;
        ifc.sck      = 1'b0;
        ifc.tx_data  = '0;
        ifc.tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {26'd0, ifc.sdo, ifc.sdo_en, ifc.busy, ifc.tx_ack, ifc.tx_done, ifc.tx_err}, 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("idle_sdo_en", {30'd0, ifc.sdo_en, ifc.busy}, 32'd0);

        run_frame(24'hA55A3C, 1'b1, 24, 8, 1'b0); wait_drain();
        run_frame(24'h123456, 1'b0, 24, 8, 1'b0); wait_drain();
        run_frame(24'hFFFFFF, 1'b1, 10, 6, 1'b0); wait_drain();
        run_frame(24'hFFFFFF, 1'b1, 30, 6, 1'b0); wait_drain();

        // reset mid-frame with cs held low across reset release
        ifc.tx_data  = 24'hFFFFFF;
        ifc.tx_valid = 1'b1;
        @(posedge clk); #1;
        ifc.cs = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            ifc.sck = 1'b1;
            repeat (8) @(posedge clk);
            #1;
            ifc.sck = 1'b0;
            repeat (8) @(posedge clk);
            #1;
        end
        check("sdo_before_reset", {30'd0, ifc.sdo, ifc.sdo_en}, 32'd3);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {29'd0, ifc.sdo, ifc.sdo_en, ifc.busy}, 32'd0);
        rx_val  = '0;
        rx_n    = 0;
        ack_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("no_frame_cs_low", {30'd0, ifc.busy, ifc.sdo_en}, 32'd0);
        check("no_ack_cs_low", 32'(ack_cnt), 32'd0);
        ifc.cs = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        run_frame(24'hC3A501, 1'b1, 24, 7, 1'b0); wait_drain();

        // back-to-back: 2 clk of cs high, new word each frame
        run_frame(24'h0F1E2D, 1'b1, 24, 6, 1'b0);
        @(posedge clk); #1;
        run_frame(24'hE1D2C3, 1'b1, 24, 6, 1'b0);
        @(posedge clk); #1;
        run_frame(24'h5A5A5A, 1'b1, 24, 6, 1'b0);
        wait_drain();

        run_frame(24'h81C3E7, 1'b1, 24, 8, 1'b1); wait_drain();

        for (int k = 0; k < 8; k++) begin
            d  = 24'($urandom);
            nb = ($urandom_range(0, 1) == 0) ? 24 : int'($urandom_range(1, 30));
            run_frame(d, 1'($urandom_range(0, 3) != 0), nb, int'($urandom_range(5, 9)),
                      1'($urandom_range(0, 3) == 0));
            wait_drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_tx_responder.md
# spi_tx_responder

SPI peripheral-side transmitter: the return path of the MCU-to-FPGA SPI link. It sits beside the existing SPI receiver on the same cs/sck pins. It drives a new sdo pin back to the MCU, shifting out a parallel response word (status, score, readback data) MSB-first in SPI mode 0. All logic runs on the fabric clock; cs and sck are synchronized and edge-detected, never used as clocks.

## Interface
Parameters:
- NBYTES, 3, response length in bytes; the frame is 8*NBYTES bits.
- SYNC_STAGES, 2, flip-flop stages on each of cs and sck (minimum 2).

Ports:
- clk  input  1  fabric clock; the only clock in the block.
- reset  input  1  asynchronous, active-high; clears all state.
- cs  input  1  SPI chip select, active-low, from the MCU.
- sck  input  1  SPI clock from the MCU (mode 0, idle low).
- tx_data  input  8*NBYTES  response word; byte 0 is the MSB byte.
- tx_valid  input  1  tx_data holds a fresh response.
- tx_ack  output  1  one-cycle pulse when tx_data is latched.
- sdo  output  1  serial data to the MCU.
- sdo_en  output  1  pad output enable; high only while a frame is active.
- busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse at frame end (cs deassert).
- tx_err  output  1  valid with tx_done; bit count at frame end was not 8*NBYTES.

## Operation
- Synchronizers: cs_s reset value 1; sck_s reset value 0. Edge detectors are registered and give sck_rise, sck_fall, cs_fall, cs_rise.
- FSM states:
  - WAIT_HIGH (reset state): leaves to IDLE once cs_s=1. This blocks a false frame when cs is already low when reset releases.
  - IDLE → SHIFT on cs_fall.
  - SHIFT → IDLE on cs_rise.
  - Reset from any state → WAIT_HIGH.
- Load on the cs_fall cycle:
  - shift_reg ← tx_valid ? tx_data : all zeros.
  - tx_ack=1 only if tx_valid=1.
  - bit_cnt ← 0.
  - sdo presents shift_reg MSB from the next cycle.
- SHIFT state:
  - sck_rise: bit_cnt increments (the MCU samples on this edge). bit_cnt saturates at 8*NBYTES+1.
  - sck_fall: shift_reg shifts left and zero-fills. sdo = shift_reg MSB.
  - Overrun: sck edges beyond 8*NBYTES clock out zeros.
- End of frame, on cs_rise in SHIFT:
  - tx_done=1 for one cycle.
  - tx_err = (bit_cnt != 8*NBYTES).
  - sdo_en ← 0, sdo ← 0, busy ← 0.
- bit_cnt width: $clog2(8*NBYTES+2).
- sdo_en = busy = (state==SHIFT), both registered.
- Simultaneous cs_rise and sck edge in one cycle: cs_rise wins. The sck edge is ignored for counting and shifting.
- Reset mid-frame: all outputs go to 0 immediately. No tx_done is issued. The next frame requires cs to be seen high first.

## Timing
- Reset values: sdo=0, sdo_en=0, busy=0, tx_ack=0, tx_done=0, tx_err=0; state=WAIT_HIGH.
- Input-to-edge-detect latency: SYNC_STAGES+1 clk cycles (3 by default).
- First bit: sdo valid SYNC_STAGES+2 clk after the physical cs fall. The MCU must not raise sck earlier.
- Subsequent bits: sdo updates SYNC_STAGES+2 clk after the physical sck fall. The sck half-period must be ≥ SYNC_STAGES+3 clk cycles (5 at default).
- tx_done: SYNC_STAGES+2 clk after the physical cs rise.
- tx_valid/tx_data are sampled only on the cs_fall cycle. The producer holds them until tx_ack, or updates them freely while busy=0.

## Test plan
- Nominal frame: NBYTES=3, tx_data=24'hA55A3C, tx_valid=1, 24 mode-0 sck cycles at half-period 8 clk.
  - MCU samples 0xA5,0x5A,0x3C.
  - tx_ack pulses once.
  - tx_done=1 with tx_err=0.
  - sdo_en high exactly during the frame.
- No data: tx_valid=0, 24 sck cycles.
  - 24 zero bits, no tx_ack, tx_err=0.
- Short and long frames, tx_data=24'hFFFFFF:
  - cs raised after 10 bits → tx_err=1.
  - 30 bits → bits 25–30 read 0, tx_err=1.
- Reset inside a frame after 12 bits, with cs held low through reset release.
  - sdo/sdo_en go 0 at once, no tx_done.
  - No frame starts until cs goes high then low.
  - The next full frame is correct.
- Back-to-back frames with 2 clk of cs high between them and tx_data changed between frames.
  - Each frame carries its own latched word.
  - One tx_ack and one tx_done per frame.
- Edge collision: cs rise and the 24th sck fall land in the same synced cycle.
  - tx_done with tx_err=0.
  - No extra shift is visible.
